uart_mmio: RTL and testbench

- Memory-mapped UART peripheral that sits directly downstream of the core's load/store port.
- Address-decodes core bus cycles and pushes store bytes into a TX FIFO, which drains to the UART AXI-stream input.
- Fills an RX FIFO from the UART AXI-stream output; loads from the RX data register pop it.
- Lets booted software do console I/O once the boot loader releases the UART.

---
 rtl/uart_mmio_pkg.sv | 35 +++
 rtl/uart_mmio_fifo.sv | 47 ++++
 rtl/uart_mmio.sv | 115 +++++++++++
 tb/tb_uart_mmio.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Register map, STATUS bit positions and shared helpers for the memory-mapped UART.
package uart_mmio_pkg;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_RXDATA = 2'd1;
   localparam logic [1:0] OFF_STATUS = 2'd2;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_EMPTY = 2;
   localparam int ST_RX_FULL  = 3;
   localparam int ST_TX_DROP  = 4;

   localparam int RXDATA_VLD = 31;

   typedef struct packed {
      logic tx_drop;
      logic rx_full;
      logic rx_empty;
      logic tx_empty;
      logic tx_full;
   } status_t;

   function automatic logic [31:0] status_word(input status_t st);
      logic [31:0] w;
      w              = '0;
      w[ST_TX_FULL]  = st.tx_full;
      w[ST_TX_EMPTY] = st.tx_empty;
      w[ST_RX_EMPTY] = st.rx_empty;
      w[ST_RX_FULL]  = st.rx_full;
      w[ST_TX_DROP]  = st.tx_drop;
      return w;
   endfunction

endpackage

// File: rtl/uart_mmio_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop frees the slot a same-cycle push needs when full.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = clk_en & pop & ~empty;
   assign do_push = clk_en & push & (~full | do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage carries no reset; contents are only visible through the pointers.
   always_ff @(posedge clk) begin
      if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_mmio.sv
// Core load/store port to UART streams: TXDATA store queue, RXDATA load pop, STATUS flags.
module uart_mmio
   import uart_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic        i_read_req,
   input  logic [31:0] i_read_addr,
   output logic [31:0] o_read_data,
   output logic        o_read_hit,
   input  logic        i_write_enable,
   input  logic [3:0]  i_byte_enable,
   input  logic [31:0] i_write_addr,
   input  logic [31:0] i_write_data,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic        o_rx_ready
);

   logic       rd_hit, wr_hit;
   logic [1:0] rd_off, wr_off;
   logic       tx_push, tx_pop, tx_full, tx_empty;
   logic       rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0] rx_head;
   logic       tx_drop;
   logic       drop_set, drop_clr;
   logic [31:0] rd_word;
   status_t    status;

   assign rd_hit = i_read_req     && (i_read_addr[31:4]  == BASE_ADDR[31:4]);
   assign wr_hit = i_write_enable && (i_write_addr[31:4] == BASE_ADDR[31:4]);
   assign rd_off = i_read_addr[3:2];
   assign wr_off = i_write_addr[3:2];

   assign tx_push  = clk_en & wr_hit & (wr_off == OFF_TXDATA) & i_byte_enable[0];
   assign tx_pop   = o_tx_valid & i_tx_ready;
   // A full queue still accepts the store when its head leaves in the same cycle.
   assign drop_set = tx_push & tx_full & ~tx_pop;
   assign drop_clr = clk_en & wr_hit & (wr_off == OFF_STATUS) & i_byte_enable[0]
                     & i_write_data[ST_TX_DROP];

   assign o_tx_valid = ~tx_empty & clk_en;
   assign o_rx_ready = ~rx_full & clk_en;
   assign rx_push    = i_rx_valid & o_rx_ready;
   assign rx_pop     = clk_en & rd_hit & (rd_off == OFF_RXDATA) & ~rx_empty;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .push   (tx_push),
      .pop    (tx_pop),
      .din    (i_write_data[7:0]),
      .dout   (o_tx_data),
      .full   (tx_full),
      .empty  (tx_empty)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .push   (rx_push),
      .pop    (rx_pop),
      .din    (i_rx_data),
      .dout   (rx_head),
      .full   (rx_full),
      .empty  (rx_empty)
   );

   assign status = '{tx_drop:  tx_drop,
                     rx_full:  rx_full,
                     rx_empty: rx_empty,
                     tx_empty: tx_empty,
                     tx_full:  tx_full};

   always_comb begin
      rd_word = '0;
      case (rd_off)
         OFF_RXDATA: begin
            if (!rx_empty) begin
               rd_word[7:0]       = rx_head;
               rd_word[RXDATA_VLD] = 1'b1;
            end
         end
         OFF_STATUS: rd_word = status_word(status);
         default:    rd_word = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_read_data <= '0;
         o_read_hit  <= 1'b0;
         tx_drop     <= 1'b0;
      end else if (clk_en) begin
         o_read_hit  <= rd_hit;
         o_read_data <= rd_hit ? rd_word : 32'h0;
         if (drop_clr)      tx_drop <= 1'b0;
         else if (drop_set) tx_drop <= 1'b1;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{i_read_addr[1:0], i_write_addr[1:0], i_byte_enable[3:1],
                          i_write_data[31:8], i_write_data[3:0]};

endmodule

// File: tb/tb_uart_mmio.sv
// Randomized and directed bench for uart_mmio against a queue-level reference model.
module tb_uart_mmio;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int D = 16;

   logic        clk = 1'b0;
   logic        rst, clk_en;
   logic        i_read_req;
   logic [31:0] i_read_addr;
   logic [31:0] o_read_data;
   logic        o_read_hit;
   logic        i_write_enable;
   logic [3:0]  i_byte_enable;
   logic [31:0] i_write_addr, i_write_data;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid, i_tx_ready;
   logic [7:0]  i_rx_data;
   logic        i_rx_valid, o_rx_ready;

   int checks = 0;
   int errors = 0;

   logic [7:0]  tx_q[$];
   logic [7:0]  rx_q[$];
   bit          m_drop;
   logic        exp_hit, exp_txv, exp_rxr;
   logic [31:0] exp_data;
   logic [7:0]  exp_txd;
   logic        obs_hit, obs_txv, obs_rxr;
   logic [31:0] obs_data;
   logic [7:0]  obs_txd;

   always #5 clk = ~clk;

   uart_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .i_read_req(i_read_req), .i_read_addr(i_read_addr),
      .o_read_data(o_read_data), .o_read_hit(o_read_hit),
      .i_write_enable(i_write_enable), .i_byte_enable(i_byte_enable),
      .i_write_addr(i_write_addr), .i_write_data(i_write_data),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
      .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready)
   );

   task automatic set_idle();
      i_read_req = 0; i_read_addr = 0;
      i_write_enable = 0; i_byte_enable = 0; i_write_addr = 0; i_write_data = 0;
      i_rx_valid = 0; i_rx_data = 0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      i_write_enable = 1; i_write_addr = a; i_write_data = d; i_byte_enable = be;
   endtask

   task automatic rd(input logic [31:0] a);
      i_read_req = 1; i_read_addr = a;
   endtask

   // One clock: sample combinational outputs, advance the model, sample registered outputs.
   task automatic tick();
      bit rhit, whit, txp;
      int txn, rxn;
      logic [31:0] st, nd;
      logic nh;
      #1;
      obs_txv = o_tx_valid; obs_txd = o_tx_data; obs_rxr = o_rx_ready;
      exp_txv = clk_en && (tx_q.size() != 0);
      exp_txd = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
      exp_rxr = clk_en && (rx_q.size() < D);
      if (rst) begin
         tx_q.delete(); rx_q.delete(); m_drop = 0; exp_hit = 0; exp_data = 0;
      end else if (clk_en) begin
         txn = tx_q.size(); rxn = rx_q.size();
         st = 0;
         st[4] = m_drop; st[3] = (rxn == D); st[2] = (rxn == 0);
         st[1] = (txn == 0); st[0] = (txn == D);
         rhit = i_read_req && (i_read_addr[31:4] == BASE[31:4]);
         whit = i_write_enable && (i_write_addr[31:4] == BASE[31:4]);
         nh = rhit; nd = 0;
         if (rhit) begin
            if (i_read_addr[3:2] == 2'd1 && rxn > 0) nd = {1'b1, 23'b0, rx_q.pop_front()};
            else if (i_read_addr[3:2] == 2'd2) nd = st;
         end
         txp = i_tx_ready && txn > 0;
         if (txp) void'(tx_q.pop_front());
         if (whit && i_byte_enable[0]) begin
            if (i_write_addr[3:2] == 2'd0) begin
               if (txn == D && !txp) m_drop = 1;
               else tx_q.push_back(i_write_data[7:0]);
            end else if (i_write_addr[3:2] == 2'd2 && i_write_data[4]) m_drop = 0;
         end
         if (i_rx_valid && rxn < D) rx_q.push_back(i_rx_data);
         exp_hit = nh; exp_data = nd;
      end
      @(posedge clk); #1;
      obs_hit = o_read_hit; obs_data = o_read_data;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1; clk_en = 1; i_tx_ready = 0; set_idle();
      tick(); tick();
      rst = 0;
      tick();
      checks++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", obs_hit); end
      checks++; if (obs_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", obs_data); end
      checks++; if (obs_txv !== 1'b0) begin errors++; $display("FAIL reset_txv: got %b expected 0", obs_txv); end
      checks++; if (obs_rxr !== 1'b1) begin errors++; $display("FAIL reset_rxr: got %b expected 1", obs_rxr); end
      rd(BASE + 8); tick(); set_idle();
      checks++; if (obs_hit !== 1'b1 || obs_data !== 32'h6) begin errors++;
         $display("FAIL reset_status: got hit=%b data=%h expected hit=1 data=00000006", obs_hit, obs_data); end
   endtask

   task automatic test_tx_basic();
      i_tx_ready = 1;
      wr(BASE, 32'h41, 4'b0001); tick();
      set_idle(); wr(BASE, 32'h42, 4'b0001); tick();
      checks++; if (obs_txv !== 1'b1 || obs_txd !== 8'h41) begin errors++;
         $display("FAIL tx_first: got v=%b d=%h expected v=1 d=41", obs_txv, obs_txd); end
      set_idle(); tick();
      checks++; if (obs_txv !== 1'b1 || obs_txd !== 8'h42) begin errors++;
         $display("FAIL tx_second: got v=%b d=%h expected v=1 d=42", obs_txv, obs_txd); end
      rd(BASE + 8); tick(); set_idle();
      checks++; if (obs_data !== 32'h6) begin errors++;
         $display("FAIL tx_drained_status: got %h expected 00000006", obs_data); end
   endtask

   task automatic test_tx_overflow();
      logic [7:0] b [17];
      i_tx_ready = 0;
      for (int i = 0; i < 17; i++) begin
         b[i] = 8'($urandom);
         set_idle(); wr(BASE, {24'h0, b[i]}, 4'b0001); tick();
      end
      set_idle(); rd(BASE + 8); tick();
      checks++; if ((obs_data & 32'h1B) !== 32'h11 || obs_data[2] !== 1'b1) begin errors++;
         $display("FAIL tx_overflow_status: got %h expected drop+full (00000015)", obs_data); end
      set_idle(); wr(BASE + 8, 32'h10, 4'b0001); tick();
      set_idle(); rd(BASE + 8); tick(); set_idle();
      checks++; if ((obs_data & 32'h1B) !== 32'h01) begin errors++;
         $display("FAIL tx_drop_clear: got %h expected tx_full only", obs_data); end
      i_tx_ready = 1;
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++; if (obs_txv !== 1'b1 || obs_txd !== b[i]) begin errors++;
            $display("FAIL tx_drain[%0d]: got v=%b d=%h expected v=1 d=%h", i, obs_txv, obs_txd, b[i]); end
      end
      tick();
      checks++; if (obs_txv !== 1'b0) begin errors++; $display("FAIL tx_drain_end: got %b expected 0", obs_txv); end
   endtask

   task automatic test_rx_basic();
      i_tx_ready = 0; set_idle();
      i_rx_valid = 1; i_rx_data = 8'h55; tick();
      i_rx_data = 8'hAA; tick();
      set_idle(); rd(BASE + 4); tick();
      checks++; if (obs_hit !== 1'b1 || obs_data !== 32'h8000_0055) begin errors++;
         $display("FAIL rx_read1: got %h expected 80000055", obs_data); end
      tick();
      checks++; if (obs_data !== 32'h8000_00AA) begin errors++;
         $display("FAIL rx_read2: got %h expected 800000aa", obs_data); end
      tick(); set_idle();
      checks++; if (obs_hit !== 1'b1 || obs_data !== 32'h0) begin errors++;
         $display("FAIL rx_read_empty: got hit=%b data=%h expected hit=1 data=0", obs_hit, obs_data); end
   endtask

   task automatic test_rx_full();
      set_idle();
      for (int i = 0; i < D; i++) begin i_rx_valid = 1; i_rx_data = 8'($urandom); tick(); end
      i_rx_data = 8'hEE; tick();
      checks++; if (obs_rxr !== 1'b0) begin errors++; $display("FAIL rx_full_ready: got %b expected 0", obs_rxr); end
      rd(BASE + 4); tick();
      checks++; if (obs_rxr !== 1'b0 || obs_data !== exp_data) begin errors++;
         $display("FAIL rx_full_pop: got rdy=%b data=%h expected rdy=0 data=%h", obs_rxr, obs_data, exp_data); end
      set_idle(); i_rx_valid = 1; i_rx_data = 8'hC3; tick();
      checks++; if (obs_rxr !== 1'b1) begin errors++; $display("FAIL rx_ready_after_pop: got %b expected 1", obs_rxr); end
      set_idle(); rd(BASE + 4); tick();
      i_rx_valid = 1; i_rx_data = 8'h3C; tick();
      set_idle(); rd(BASE + 8); tick();
      checks++; if (obs_data[3:2] !== 2'b00) begin errors++;
         $display("FAIL rx_pushpop_count: got status %h expected not full/not empty", obs_data); end
      set_idle(); i_rx_valid = 1; i_rx_data = 8'h99; tick();
      tick();
      checks++; if (obs_rxr !== 1'b0) begin errors++;
         $display("FAIL rx_refill_one: got %b expected 0 (count was 15)", obs_rxr); end
      set_idle();
      for (int i = 0; i < D; i++) begin
         rd(BASE + 4); tick();
         checks++; if (obs_data !== exp_data || obs_data[31] !== 1'b1) begin errors++;
            $display("FAIL rx_drain[%0d]: got %h expected %h", i, obs_data, exp_data); end
      end
      set_idle();
   endtask

   task automatic test_clk_en();
      logic [31:0] pd; logic ph;
      i_tx_ready = 0; set_idle();
      wr(BASE, 32'h5A, 4'b0001); tick();
      set_idle(); i_rx_valid = 1; i_rx_data = 8'h33; tick();
      set_idle(); rd(BASE + 8); tick();
      pd = obs_data; ph = obs_hit;
      clk_en = 0; wr(BASE, 32'h77, 4'b0001); rd(BASE + 4); i_rx_valid = 1; i_rx_data = 8'h11; i_tx_ready = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (obs_txv !== 1'b0 || obs_rxr !== 1'b0) begin errors++;
            $display("FAIL clken_streams: got txv=%b rxr=%b expected 0 0", obs_txv, obs_rxr); end
         checks++; if (obs_hit !== ph || obs_data !== pd) begin errors++;
            $display("FAIL clken_hold: got hit=%b data=%h expected hit=%b data=%h", obs_hit, obs_data, ph, pd); end
      end
      clk_en = 1; i_tx_ready = 0; set_idle(); rd(BASE + 8); tick();
      checks++; if (obs_data !== 32'h0 || obs_txv !== 1'b1 || obs_txd !== 8'h5A) begin errors++;
         $display("FAIL clken_after: got status=%h txv=%b txd=%h expected 0 1 5a", obs_data, obs_txv, obs_txd); end
      set_idle(); rd(BASE + 4); tick(); set_idle();
      checks++; if (obs_data !== 32'h8000_0033) begin errors++;
         $display("FAIL clken_rx: got %h expected 80000033", obs_data); end
   endtask

   task automatic test_rst_mid();
      i_tx_ready = 0; set_idle();
      wr(BASE, 32'h66, 4'b0001); tick();
      set_idle(); rst = 1; tick();
      checks++; if (obs_txv !== 1'b1) begin errors++; $display("FAIL rst_pre_txv: got %b expected 1", obs_txv); end
      rst = 0; rd(BASE + 8); tick(); set_idle();
      checks++; if (obs_txv !== 1'b0 || obs_data !== 32'h6) begin errors++;
         $display("FAIL rst_mid: got txv=%b status=%h expected 0 00000006", obs_txv, obs_data); end
   endtask

   task automatic test_random();
      logic [31:0] addrs [7];
      addrs = '{BASE, BASE + 4, BASE + 8, BASE + 12, BASE + 16, BASE - 4, 32'h1234_5670};
      for (int n = 0; n < 800; n++) begin
         rst    = ($urandom_range(0, 99) == 0);
         clk_en = ($urandom_range(0, 7) != 0);
         i_tx_ready     = ($urandom_range(0, 2) == 0);
         i_read_req     = $urandom_range(0, 1);
         i_read_addr    = addrs[$urandom_range(0, 6)] | 32'($urandom_range(0, 3));
         i_write_enable = ($urandom_range(0, 2) != 0);
         i_write_addr   = (($urandom_range(0, 3) != 0) ? BASE : addrs[$urandom_range(1, 6)])
                          | 32'($urandom_range(0, 3));
         i_write_data   = $urandom;
         i_byte_enable  = 4'($urandom);
         i_rx_valid     = $urandom_range(0, 1);
         i_rx_data      = 8'($urandom);
         tick();
         checks++; if (obs_hit !== exp_hit || obs_data !== exp_data) begin errors++;
            $display("FAIL rand_read[%0d]: got hit=%b data=%h expected hit=%b data=%h", n, obs_hit, obs_data, exp_hit, exp_data); end
         checks++; if (obs_txv !== exp_txv || (exp_txv && obs_txd !== exp_txd)) begin errors++;
            $display("FAIL rand_tx[%0d]: got v=%b d=%h expected v=%b d=%h", n, obs_txv, obs_txd, exp_txv, exp_txd); end
         checks++; if (obs_rxr !== exp_rxr) begin errors++;
            $display("FAIL rand_rxr[%0d]: got %b expected %b", n, obs_rxr, exp_rxr); end
      end
      rst = 0; clk_en = 1; set_idle();
   endtask

   initial begin
      rst = 1; clk_en = 1; i_tx_ready = 0; set_idle();
      m_drop = 0; exp_hit = 0; exp_data = 0;
      test_reset();
      test_tx_basic();
      test_tx_overflow();
      test_rx_basic();
      test_rx_full();
      test_clk_en();
      test_rst_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
